// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: RV32M multiply/divide opcodes, MDU states and constants.
package riscv_pkg;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_e;

  localparam logic [31:0] MDU_DIV0_Q = '1;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;

endpackage

// File: rtl/mdu_sign_fix.sv
// Combinational conditional two's-complement negate, used for operand magnitudes
// and for the final sign correction.
module mdu_sign_fix #(
  parameter int W = 32
) (
  input  logic         i_neg,
  input  logic [W-1:0] i_val,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + {{(W-1){1'b0}}, 1'b1}) : i_val;

endmodule

// File: rtl/pl_mdu.sv
// Iterative RV32M multiply/divide unit: W-cycle shift-add multiply or restoring
// divide on operand magnitudes, followed by a one-cycle sign fix-up.
module pl_mdu
  import riscv_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] SrcA,
  input  logic [W-1:0] SrcB,
  input  logic         flush,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result
);

  localparam int CW = $clog2(W);
  localparam logic [W-1:0]  L_ONES    = {W{1'b1}};
  localparam logic [W-1:0]  L_INT_MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic [CW-1:0] L_LAST    = CW'(W - 1);
  localparam logic [CW-1:0] L_CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  mdu_state_e    r_state;
  mdu_op_e       r_op;
  logic          r_neg_res;
  logic          r_neg_rem;
  logic [W-1:0]  r_opnd;
  logic [W-1:0]  r_acc_hi;
  logic [W-1:0]  r_acc_lo;
  logic [CW-1:0] r_count;
  logic [W-1:0]  r_result;
  logic          r_busy;
  logic          r_done;

  mdu_op_e      w_op;
  logic         w_is_div;
  logic         w_sa;
  logic         w_sb;
  logic [W-1:0] w_abs_a;
  logic [W-1:0] w_abs_b;
  logic         w_div0;
  logic         w_ovf;
  logic [W-1:0] w_fast_res;
  logic [W:0]   w_mul_sum;
  logic [W:0]   w_rem_sh;
  logic [W:0]   w_diff;
  logic         w_q_bit;
  logic [2*W-1:0] w_prod_fix;
  logic [W-1:0] w_quo_fix;
  logic [W-1:0] w_rem_fix;
  logic [W-1:0] w_fix_res;

  assign w_op     = mdu_op_e'(op);
  assign w_is_div = op[2];
  // MULHSU treats only rs1 as signed; MULHU/DIVU/REMU treat neither.
  assign w_sa = SrcA[W-1] & ((w_op == MDU_MUL) || (w_op == MDU_MULH) || (w_op == MDU_MULHSU) ||
                             (w_op == MDU_DIV) || (w_op == MDU_REM));
  assign w_sb = SrcB[W-1] & ((w_op == MDU_MUL) || (w_op == MDU_MULH) ||
                             (w_op == MDU_DIV) || (w_op == MDU_REM));

  mdu_sign_fix #(.W(W)) u_abs_a (.i_neg(w_sa), .i_val(SrcA), .o_val(w_abs_a));
  mdu_sign_fix #(.W(W)) u_abs_b (.i_neg(w_sb), .i_val(SrcB), .o_val(w_abs_b));

  assign w_div0 = w_is_div && (SrcB == {W{1'b0}});
  assign w_ovf  = ((w_op == MDU_DIV) || (w_op == MDU_REM)) && (SrcA == L_INT_MIN) && (SrcB == L_ONES);
  // op[1] separates REM/REMU from DIV/DIVU.
  assign w_fast_res = w_div0 ? (op[1] ? SrcA : L_ONES) : (op[1] ? {W{1'b0}} : L_INT_MIN);

  assign w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : {(W+1){1'b0}});
  assign w_rem_sh  = {r_acc_hi, r_acc_lo[W-1]};
  assign w_diff    = w_rem_sh - {1'b0, r_opnd};
  assign w_q_bit   = ~w_diff[W];

  mdu_sign_fix #(.W(2*W)) u_fix_prod (.i_neg(r_neg_res), .i_val({r_acc_hi, r_acc_lo}), .o_val(w_prod_fix));
  mdu_sign_fix #(.W(W))   u_fix_quo  (.i_neg(r_neg_res), .i_val(r_acc_lo), .o_val(w_quo_fix));
  mdu_sign_fix #(.W(W))   u_fix_rem  (.i_neg(r_neg_rem), .i_val(r_acc_hi), .o_val(w_rem_fix));

  // Output selection from the sign-corrected datapath.
  always_comb begin
    w_fix_res = {W{1'b0}};
    case (r_op)
      MDU_MUL:                          w_fix_res = w_prod_fix[W-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU:  w_fix_res = w_prod_fix[2*W-1:W];
      MDU_DIV, MDU_DIVU:                w_fix_res = w_quo_fix;
      MDU_REM, MDU_REMU:                w_fix_res = w_rem_fix;
      default:                          w_fix_res = {W{1'b0}};
    endcase
  end

  // Control FSM and shared accumulator datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_op      <= MDU_MUL;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_opnd    <= {W{1'b0}};
      r_acc_hi  <= {W{1'b0}};
      r_acc_lo  <= {W{1'b0}};
      r_count   <= {CW{1'b0}};
      r_result  <= {W{1'b0}};
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start && !flush) begin
            r_op      <= w_op;
            r_neg_res <= w_sa ^ w_sb;
            r_neg_rem <= w_sa;
            r_count   <= {CW{1'b0}};
            if (w_div0 || w_ovf) begin
              r_result <= w_fast_res;
              r_done   <= 1'b1;
              r_state  <= DONE;
            end else begin
              // Multiply: multiplicand in r_opnd, multiplier shifts out of acc_lo.
              // Divide: divisor in r_opnd, dividend shifts out of acc_lo.
              r_opnd   <= w_is_div ? w_abs_b : w_abs_a;
              r_acc_hi <= {W{1'b0}};
              r_acc_lo <= w_is_div ? w_abs_a : w_abs_b;
              r_busy   <= 1'b1;
              r_state  <= CALC;
            end
          end
        end
        CALC: begin
          if (flush) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            if (r_op[2]) begin
              r_acc_hi <= w_q_bit ? w_diff[W-1:0] : w_rem_sh[W-1:0];
              r_acc_lo <= {r_acc_lo[W-2:0], w_q_bit};
            end else begin
              {r_acc_hi, r_acc_lo} <= {w_mul_sum, r_acc_lo[W-1:1]};
            end
            r_count <= r_count + L_CNT_ONE;
            if (r_count == L_LAST) begin
              r_state <= FIX;
            end
          end
        end
        FIX: begin
          r_busy <= 1'b0;
          if (flush) begin
            r_state <= IDLE;
          end else begin
            r_result <= w_fix_res;
            r_done   <= 1'b1;
            r_state  <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_pl_mdu.sv
// Directed self-checking bench for pl_mdu: results, latencies, fast paths,
// flush, ignored starts and asynchronous reset.
module tb_pl_mdu;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_checks;
  int n_errors;

  pl_mdu #(.W(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .SrcA   (SrcA),
    .SrcB   (SrcB),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one op, wait (bounded) for done, check result, latency and busy.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_r,
                        input int exp_lat, input bit noise);
    int lat;
    op = o; SrcA = a; SrcB = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 60) begin
      if (noise) begin
        start = (lat == 3 || lat == 4 || lat == 20);
        op = 3'd5; SrcA = 32'd1000; SrcB = 32'd10;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk_eq({tag, "_done"}, {63'd0, done}, 64'd1);
    chk_eq({tag, "_res"}, {32'd0, result}, {32'd0, exp_r});
    chk_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk_eq({tag, "_busy"}, {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0; start = 1'b0; op = 3'd0; SrcA = 32'd0; SrcB = 32'd0; flush = 1'b0;
    #12;
    chk_eq("rst_busy", {63'd0, busy}, 64'd0);
    chk_eq("rst_done", {63'd0, done}, 64'd0);
    chk_eq("rst_result", {32'd0, result}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("mul",      3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 1'b0);
    run_op("mulh",     3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 1'b0);
    run_op("mulhu",    3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 1'b0);
    run_op("mulhsu",   3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 1'b0);
    run_op("div",      3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, 1'b0);
    run_op("rem",      3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, 1'b0);
    run_op("div_nb",   3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, 1'b0);
    run_op("rem_nb",   3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1,         34, 1'b0);
    run_op("divu",     3'd5, 32'd100,       32'd7,         32'd14,        34, 1'b0);
    run_op("remu",     3'd7, 32'd100,       32'd7,         32'd2,         34, 1'b0);
    run_op("divu_z",   3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1,  1'b0);
    run_op("remu_z",   3'd7, 32'd5,         32'd0,         32'd5,         1,  1'b0);
    run_op("div_z",    3'd4, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 1,  1'b0);
    run_op("rem_z",    3'd6, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1,  1'b0);
    run_op("div_ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  1'b0);
    run_op("rem_ovf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1,  1'b0);
    run_op("divu_pre", 3'd5, 32'd100,       32'd7,         32'd14,        34, 1'b0);

    // Flush at CALC cycle 10: back to IDLE, no done, result kept.
    op = 3'd0; SrcA = 32'd3; SrcB = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    chk_eq("fl_busy_before", {63'd0, busy}, 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk_eq("fl_busy", {63'd0, busy}, 64'd0);
    chk_eq("fl_done", {63'd0, done}, 64'd0);
    chk_eq("fl_result", {32'd0, result}, 64'd14);
    run_op("after_fl", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 1'b0);

    // Flush and start together in IDLE: nothing accepted.
    op = 3'd5; SrcA = 32'd9; SrcB = 32'd0; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk_eq("fls_busy", {63'd0, busy}, 64'd0);
    chk_eq("fls_done", {63'd0, done}, 64'd0);
    chk_eq("fls_result", {32'd0, result}, 64'hFFFF_FFFE);

    // Starts while busy are ignored; result and latency follow the first op.
    run_op("noise", 3'd0, 32'd6, 32'd7, 32'd42, 34, 1'b1);

    // Asynchronous reset in the middle of CALC.
    op = 3'd0; SrcA = 32'd11; SrcB = 32'd13; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2;
    rst_n = 1'b0;
    #1;
    chk_eq("mrst_busy", {63'd0, busy}, 64'd0);
    chk_eq("mrst_done", {63'd0, done}, 64'd0);
    chk_eq("mrst_result", {32'd0, result}, 64'd0);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("after_rst", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 34, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
